// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the block-RAM stream reader: FSM state encoding and a
// width-parameterised bit-reverse helper (also used by NTT address generators).
package bram_stream_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned BITREV_MAX_W = 32;
  localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < BITREV_MAX_W; b++) begin
      if (b < w) begin
        r[BITREV_IDX_W'(b)] = v[BITREV_IDX_W'(w - 1 - b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_stream_reader_skid.sv
// stream_skid_buf2: 2-entry registered FIFO carrying data+last, with the head
// entry driving the stream outputs directly from flops.
module stream_skid_buf2 #(
  parameter int unsigned DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             valid,
  output logic [DSIZE-1:0] data,
  output logic             last,
  output logic [1:0]       occ
);

  logic [DSIZE-1:0] ent1_data;
  logic             ent1_last;

  // Head entry (data/last) is the output register; ent1 is the overflow slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      data      <= '0;
      last      <= 1'b0;
      ent1_data <= '0;
      ent1_last <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            data <= push_data;
            last <= push_last;
          end else begin
            ent1_data <= push_data;
            ent1_last <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          data <= ent1_data;
          // Draining to empty must not leave a stale last flag behind.
          last <= (occ == 2'd2) ? ent1_last : 1'b0;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            data      <= ent1_data;
            last      <= ent1_last;
            ent1_data <= push_data;
            ent1_last <= push_last;
          end else begin
            data <= push_data;
            last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ != 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side controller for a 1-cycle-latency block RAM: walks an address range
// and streams the words out with valid/ready/last. BRAM_READER_BITREV_EN
// selects bit-reversed offsets (NTT input order) instead of linear order.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   len,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] raddr,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last
);

  localparam int unsigned LW = DEPTH + 1;

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] base_q;
  logic [DEPTH-1:0] raddr_q;
  logic [DEPTH-1:0] offset;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    cnt;
  logic             inflight;
  logic             inflight_last;
  logic [1:0]       occ;
  logic             pop;
  logic             issue_ok;
  logic             issue_last;
  logic             issue;

  assign pop        = m_valid & m_ready;
  // Count buffered words plus the one arriving from the RAM, net of this pop.
  assign issue_ok   = ((3'(occ) + 3'(inflight)) - 3'(pop)) < 3'd2;
  assign issue_last = (cnt == (len_q - LW'(1)));

`ifdef BRAM_READER_BITREV_EN
  assign offset = DEPTH'(bitrev(BITREV_MAX_W'(cnt[DEPTH-1:0]), DEPTH));
`else
  assign offset = cnt[DEPTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue && issue_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight && pop && m_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The RAM registers the address itself, so raddr is presented in the issue
  // cycle to meet the 3-cycle start-to-data latency; it holds otherwise.
  always_comb begin
    issue = 1'b0;
    raddr = raddr_q;
    if ((state == ST_ISSUE) && issue_ok) begin
      issue = 1'b1;
      raddr = base_q + offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      len_q         <= '0;
      cnt           <= '0;
      raddr_q       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy     <= (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
      done     <= (state_nxt == ST_DONE);
      inflight <= issue;
      if (issue) begin
        raddr_q       <= raddr;
        inflight_last <= issue_last;
        cnt           <= cnt + LW'(1);
      end
      if ((state == ST_IDLE) && start) begin
        base_q <= base_addr;
        len_q  <= len;
        cnt    <= '0;
      end
    end
  end

  stream_skid_buf2 #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (rdata),
    .push_last (inflight_last),
    .pop       (pop),
    .valid     (m_valid),
    .data      (m_data),
    .last      (m_last),
    .occ       (occ)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 1-cycle-latency RAM model
// holding RAM[a] = a + 100.
module tb_bram_stream_reader;

`ifdef BRAM_READER_BITREV_EN
  localparam int unsigned DEPTH = 3;
`else
  localparam int unsigned DEPTH = 10;
`endif
  localparam int unsigned DSIZE  = 32;
  localparam int unsigned NWORDS = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [DEPTH-1:0] base_addr;
  logic [DEPTH:0]   len;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] raddr;
  logic [DSIZE-1:0] rdata;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  logic [DSIZE-1:0] mem [NWORDS];

  int n_checks = 0;
  int n_fail   = 0;

  bram_stream_reader #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DEPTH-1:0] exp_addr(input logic [DEPTH-1:0] b, input int i);
`ifdef BRAM_READER_BITREV_EN
    logic [DEPTH-1:0] o;
    case (i)
      0: o = 3'd0;  1: o = 3'd4;  2: o = 3'd2;  3: o = 3'd6;
      4: o = 3'd1;  5: o = 3'd5;  6: o = 3'd3;  default: o = 3'd7;
    endcase
    return b + o;
`else
    return b + DEPTH'(i);
`endif
  endfunction

  // Start a transfer with m_ready=1 and check every cycle up to two after done.
  task automatic run_xfer(input logic [DEPTH-1:0] b, input int n, input bit spurious);
    @(negedge clk);
    start = 1'b1; base_addr = b; len = (DEPTH+1)'(n);
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (spurious && c == 2) begin
        start = 1'b1; base_addr = b + DEPTH'(3); len = (DEPTH+1)'(1);
      end
      if (c <= n) chk($sformatf("raddr c%0d", c), 32'(raddr), 32'(exp_addr(b, c - 1)));
      chk($sformatf("m_valid c%0d", c), 32'(m_valid), 32'(c >= 3 && c <= n + 2));
      if (c >= 3 && c <= n + 2) begin
        chk($sformatf("m_data c%0d", c), m_data, 32'(exp_addr(b, c - 3)) + 32'd100);
        chk($sformatf("m_last c%0d", c), 32'(m_last), 32'(c == n + 2));
      end
      chk($sformatf("done c%0d", c), 32'(done), 32'(c == n + 3));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= n + 2));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},    32'(busy),    32'd0);
    chk({tag, " done"},    32'(done),    32'd0);
    chk({tag, " m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, " m_last"},  32'(m_last),  32'd0);
    chk({tag, " m_data"},  m_data,       32'd0);
    chk({tag, " raddr"},   32'(raddr),   32'd0);
  endtask

  initial begin
    int  got;
    bit  saw_done;
    bit  prev_stall;
    logic [DSIZE-1:0] prev_data;
    logic prev_last;

    for (int i = 0; i < int'(NWORDS); i++) mem[i] = 32'(i + 100);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

`ifdef BRAM_READER_BITREV_EN
    run_xfer(3'd0, 8, 1'b0);
`else
    // Linear read: data 105..108 in cycles 3..6, done in cycle 7.
    run_xfer(10'd5, 4, 1'b0);

    // Address wrap across the top of memory.
    run_xfer(10'd1022, 4, 1'b0);

    // Start while busy must be ignored.
    run_xfer(10'd40, 5, 1'b1);

    // len = 0: done the cycle after start, no stream output.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd7; len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy", 32'(busy), 32'd0);
    chk("len0 m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("len0 done clr", 32'(done), 32'd0);
    chk("len0 m_valid2", 32'(m_valid), 32'd0);

    // Backpressure: m_ready 1,0,0 repeating; words 100..105 exactly once, in order.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; len = 11'd6;
    got = 0; saw_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 1; c <= 80 && !saw_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (prev_stall) begin
        chk("bp hold valid", 32'(m_valid), 32'd1);
        chk("bp hold data", m_data, prev_data);
        chk("bp hold last", 32'(m_last), 32'(prev_last));
      end
      if (done) begin
        saw_done = 1'b1;
        chk("bp words at done", 32'(got), 32'd6);
        chk("bp valid at done", 32'(m_valid), 32'd0);
      end
      m_ready = (c % 3 == 1);
      if (m_valid && m_ready) begin
        chk("bp data", m_data, 32'(got + 100));
        chk("bp last", 32'(m_last), 32'(got == 5));
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    chk("bp done seen", 32'(saw_done), 32'd1);
    chk("bp word count", 32'(got), 32'd6);
    m_ready = 1'b1;

    // Reset during word 3 of an 8-word transfer, then a clean 2-word transfer.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; len = 11'd8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset m_data", m_data, 32'd102);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(10'd0, 2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
